// File: rtl/ten_min_countdown.sv
`default_nettype none
// ============================================================================
//  Module      : ten_min_countdown
//  Description : BCD countdown timer (M:SS.t) that steps down one tenth of a
//                second per TENTH_DIV clocks, raises a one-cycle done pulse on
//                reaching 0:00.0 and then holds in EXPIRED until reloaded.
//  Revision    : 1.0  initial release
// ============================================================================
module ten_min_countdown #(
    parameter int TENTH_DIV = 10,
    parameter int PRESC_W   = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_min,
    input  logic [2:0] load_sec_tens,
    input  logic [3:0] load_sec_ones,
    input  logic [3:0] load_tenths,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] minutes,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] tenths,
    output logic       running,
    output logic       paused,
    output logic       expired,
    output logic       done
);

    localparam logic [PRESC_W-1:0] c_TICK_LAST = PRESC_W'(TENTH_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSE   = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] w_presc_nxt;
    logic [3:0]         r_min,  w_min_nxt;
    logic [2:0]         r_st,   w_st_nxt;
    logic [3:0]         r_so,   w_so_nxt;
    logic [3:0]         r_tn,   w_tn_nxt;
    logic               r_done, w_done_nxt;

    // Value after one tenth is subtracted (only ever used when value != 0)
    logic [3:0] w_min_dec;
    logic [2:0] w_st_dec;
    logic [3:0] w_so_dec;
    logic [3:0] w_tn_dec;
    logic       w_is_zero;
    logic       w_is_last;

    assign w_is_zero = (r_min == 4'd0) && (r_st == 3'd0) && (r_so == 4'd0) && (r_tn == 4'd0);
    assign w_is_last = (r_min == 4'd0) && (r_st == 3'd0) && (r_so == 4'd0) && (r_tn == 4'd1);

    // BCD borrow chain: each digit wraps to its maximum when it borrows
    always_comb begin
        w_min_dec = r_min;
        w_st_dec  = r_st;
        w_so_dec  = r_so;
        w_tn_dec  = r_tn;
        if (r_tn != 4'd0) begin
            w_tn_dec = r_tn - 4'd1;
        end else begin
            w_tn_dec = 4'd9;
            if (r_so != 4'd0) begin
                w_so_dec = r_so - 4'd1;
            end else begin
                w_so_dec = 4'd9;
                if (r_st != 3'd0) begin
                    w_st_dec = r_st - 3'd1;
                end else begin
                    w_st_dec  = 3'd5;
                    w_min_dec = r_min - 4'd1;
                end
            end
        end
    end

    // Next-state logic: load beats stop, stop beats start, start beats the tick
    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_min_nxt   = r_min;
        w_st_nxt    = r_st;
        w_so_nxt    = r_so;
        w_tn_nxt    = r_tn;
        w_done_nxt  = 1'b0;
        if (load) begin
            // Out-of-range digits clamp to the largest legal BCD value
            w_min_nxt   = (load_min      > 4'd9) ? 4'd9 : load_min;
            w_st_nxt    = (load_sec_tens > 3'd5) ? 3'd5 : load_sec_tens;
            w_so_nxt    = (load_sec_ones > 4'd9) ? 4'd9 : load_sec_ones;
            w_tn_nxt    = (load_tenths   > 4'd9) ? 4'd9 : load_tenths;
            w_state_nxt = S_IDLE;
            w_presc_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!stop && start) begin
                        w_presc_nxt = '0;
                        if (w_is_zero) begin
                            w_state_nxt = S_EXPIRED;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        w_state_nxt = S_PAUSE;
                    end else if (r_presc == c_TICK_LAST) begin
                        w_presc_nxt = '0;
                        w_min_nxt   = w_min_dec;
                        w_st_nxt    = w_st_dec;
                        w_so_nxt    = w_so_dec;
                        w_tn_nxt    = w_tn_dec;
                        if (w_is_last) begin
                            w_state_nxt = S_EXPIRED;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_presc_nxt = r_presc + 1'b1;
                    end
                end
                S_PAUSE: begin
                    // Prescaler is left untouched so a partial tenth is kept
                    if (!stop && start) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: begin
                    // EXPIRED: hold zero until a load or reset
                    w_state_nxt = S_EXPIRED;
                end
            endcase
        end
    end

    // State, prescaler, digit and done registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_min   <= 4'd0;
            r_st    <= 3'd0;
            r_so    <= 4'd0;
            r_tn    <= 4'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_min   <= w_min_nxt;
            r_st    <= w_st_nxt;
            r_so    <= w_so_nxt;
            r_tn    <= w_tn_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign minutes  = r_min;
    assign sec_tens = r_st;
    assign sec_ones = r_so;
    assign tenths   = r_tn;
    assign running  = (r_state == S_RUN);
    assign paused   = (r_state == S_PAUSE);
    assign expired  = (r_state == S_EXPIRED);
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ten_min_countdown.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ten_min_countdown
//  Description : Directed bench for ten_min_countdown with TENTH_DIV=4.
//                Stimulus queues expected snapshots and done-pulse cycles;
//                a monitor on the falling edge pops and compares them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ten_min_countdown;

    localparam int TENTH_DIV = 4;
    localparam int PRESC_W   = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_min = '0;
    logic [2:0] load_sec_tens = '0;
    logic [3:0] load_sec_ones = '0;
    logic [3:0] load_tenths = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] minutes;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] tenths;
    logic       running;
    logic       paused;
    logic       expired;
    logic       done;

    ten_min_countdown #(.TENTH_DIV(TENTH_DIV), .PRESC_W(PRESC_W)) dut (
        .clk(clk), .reset(reset), .load(load),
        .load_min(load_min), .load_sec_tens(load_sec_tens),
        .load_sec_ones(load_sec_ones), .load_tenths(load_tenths),
        .start(start), .stop(stop),
        .minutes(minutes), .sec_tens(sec_tens), .sec_ones(sec_ones), .tenths(tenths),
        .running(running), .paused(paused), .expired(expired), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [18:0] val;   // {min, sec_tens, sec_ones, tenths, run, pause, expired, done}
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Inputs change 2 time units after a rising edge; state is then that of edge 'cyc'
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic expect_now(input string name, input logic [3:0] mn, input logic [2:0] st,
                              input logic [3:0] so, input logic [3:0] tn,
                              input logic r, input logic p, input logic e, input logic d);
        exp_t x;
        x.cyc  = cyc;
        x.val  = {mn, st, so, tn, r, p, e, d};
        x.name = name;
        exp_q.push_back(x);
    endtask

    task automatic do_load(input logic [3:0] mn, input logic [2:0] st,
                           input logic [3:0] so, input logic [3:0] tn);
        load = 1'b1; load_min = mn; load_sec_tens = st; load_sec_ones = so; load_tenths = tn;
        tick(1);
        load = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Monitor: compares queued snapshots and every done pulse on the falling edge
    always @(negedge clk) begin
        logic [18:0] act;
        act = {minutes, sec_tens, sec_ones, tenths, running, paused, expired, done};
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t x;
            x = exp_q.pop_front();
            n_checks++;
            if (x.cyc != cyc)
                $display("FAIL %s: snapshot missed (due cycle %0d, now %0d)", x.name, x.cyc, cyc);
            else if (act !== x.val)
                $display("FAIL %s: got %h expected %h (cycle %0d)", x.name, act, x.val, cyc);
            else
                n_pass++;
        end
        if (done === 1'b1) begin
            n_checks++;
            if (done_q.size() == 0)
                $display("FAIL done_pulse: unexpected done at cycle %0d expected none", cyc);
            else begin
                int d;
                d = done_q.pop_front();
                if (d != cyc)
                    $display("FAIL done_pulse: got done at cycle %0d expected cycle %0d", cyc, d);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(2);
        expect_now("reset", 4'd0, 3'd0, 4'd0, 4'd0, 0, 0, 0, 0);
        tick(1);
        reset = 1'b1;
        tick(1);

        // Load 1:00.0, first decrement after TENTH_DIV edges with full borrow
        do_load(4'd1, 3'd0, 4'd0, 4'd0);
        expect_now("load_1m", 4'd1, 3'd0, 4'd0, 4'd0, 0, 0, 0, 0);
        pulse_start();
        expect_now("start_run", 4'd1, 3'd0, 4'd0, 4'd0, 1, 0, 0, 0);
        tick(3);
        expect_now("pre_tick", 4'd1, 3'd0, 4'd0, 4'd0, 1, 0, 0, 0);
        tick(1);
        expect_now("borrow_59_9", 4'd0, 3'd5, 4'd9, 4'd9, 1, 0, 0, 0);

        // Expiry from 0:00.3
        do_load(4'd0, 3'd0, 4'd0, 4'd3);
        pulse_start();
        done_q.push_back(cyc + 12);
        tick(11);
        expect_now("last_tenth", 4'd0, 3'd0, 4'd0, 4'd1, 1, 0, 0, 0);
        tick(1);
        expect_now("expire", 4'd0, 3'd0, 4'd0, 4'd0, 0, 0, 1, 1);
        tick(1);
        expect_now("done_drop", 4'd0, 3'd0, 4'd0, 4'd0, 0, 0, 1, 0);
        start = 1'b1;
        tick(3);
        start = 1'b0;
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        expect_now("expired_hold", 4'd0, 3'd0, 4'd0, 4'd0, 0, 0, 1, 0);

        // Pause at prescaler 2 for 10 cycles; resume keeps the partial tenth
        do_load(4'd0, 3'd0, 4'd1, 4'd0);
        pulse_start();
        tick(2);
        stop = 1'b1;
        tick(10);
        expect_now("paused", 4'd0, 3'd0, 4'd1, 4'd0, 0, 1, 0, 0);
        stop = 1'b0;
        pulse_start();
        expect_now("resumed", 4'd0, 3'd0, 4'd1, 4'd0, 1, 0, 0, 0);
        tick(1);
        expect_now("resume_wait", 4'd0, 3'd0, 4'd1, 4'd0, 1, 0, 0, 0);
        tick(1);
        expect_now("resume_dec", 4'd0, 3'd0, 4'd0, 4'd9, 1, 0, 0, 0);

        // Priority: stop beats start; load beats stop; start on zero expires
        start = 1'b1; stop = 1'b1;
        tick(1);
        start = 1'b0; stop = 1'b0;
        expect_now("stop_wins", 4'd0, 3'd0, 4'd0, 4'd9, 0, 1, 0, 0);
        pulse_start();
        stop = 1'b1;
        do_load(4'd2, 3'd3, 4'd4, 4'd5);
        stop = 1'b0;
        expect_now("load_wins", 4'd2, 3'd3, 4'd4, 4'd5, 0, 0, 0, 0);
        do_load(4'd0, 3'd0, 4'd0, 4'd0);
        done_q.push_back(cyc + 1);
        pulse_start();
        expect_now("zero_start", 4'd0, 3'd0, 4'd0, 4'd0, 0, 0, 1, 1);

        // Saturating load and full countdown of 5999 tenths
        do_load(4'd12, 3'd7, 4'd15, 4'd10);
        expect_now("saturate", 4'd9, 3'd5, 4'd9, 4'd9, 0, 0, 0, 0);
        pulse_start();
        done_q.push_back(cyc + 5999 * TENTH_DIV);
        tick(600 * TENTH_DIV);
        expect_now("mid_8_59_9", 4'd8, 3'd5, 4'd9, 4'd9, 1, 0, 0, 0);
        tick(5999 * TENTH_DIV - 1 - 600 * TENTH_DIV);
        expect_now("full_last", 4'd0, 3'd0, 4'd0, 4'd1, 1, 0, 0, 0);
        tick(1);
        expect_now("full_expire", 4'd0, 3'd0, 4'd0, 4'd0, 0, 0, 1, 1);

        // Asynchronous reset between edges while running
        do_load(4'd0, 3'd0, 4'd5, 4'd0);
        pulse_start();
        tick(TENTH_DIV + 1);
        expect_now("pre_reset", 4'd0, 3'd0, 4'd4, 4'd9, 1, 0, 0, 0);
        tick(1);
        reset = 1'b0;
        expect_now("async_reset", 4'd0, 3'd0, 4'd0, 4'd0, 0, 0, 0, 0);
        tick(1);
        reset = 1'b1;
        tick(2);
        expect_now("post_reset", 4'd0, 3'd0, 4'd0, 4'd0, 0, 0, 0, 0);

        tick(2);
        @(negedge clk);
        #1;
        n_checks++;
        if (done_q.size() != 0 || exp_q.size() != 0)
            $display("FAIL drain: got %0d done and %0d snapshots pending expected 0",
                     done_q.size(), exp_q.size());
        else
            n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
